seven_seg_scan_decoder: RTL and testbench
=========================================

// Module: seven_seg_scan_decoder
// PURPOSE
//  Receive end of the multiplexed 4-digit seven-segment interface. Watches the active-low anode
//  strobes and segment lines driven by the display driver and reconstructs the four 5-bit digit
//  codes. Used for on-board loopback checking and self-test of the display path.
//  Publishes a frame only after it has been stable for a set number of scans.
// PARAMETERS
//  SETTLE_CYCLES  4   cycles an anode must be held steady before the segments are sampled
//  STABLE_FRAMES  2   consecutive identical complete frames required to update the outputs
//  TIMEOUT_W      18  width of the stall counter; a stall is 2**TIMEOUT_W-1 cycles with no anode change
// PORTS
//  clk          in   1  system clock
//  rst_n        in   1  asynchronous reset, active-low
//  seg          in   7  {g,f,e,d,c,b,a}, active-low segments
//  dp           in   1  decimal point, active-low
//  an           in   4  anode enables, active-low; an[0] selects digit0
//  digit0..3    out  5  decoded codes for each digit; reset value 5'h10 (blank)
//  dp_out       out  4  captured decimal points, active-low; reset value 4'hF
//  frame_valid  out  1  high while digit0..3 hold a published frame; reset value 0
//  new_frame    out  1  one-cycle pulse when the outputs update; reset value 0
//  scan_error   out  1  one-cycle pulse on an illegal anode pattern or a stall; reset value 0
//  bad_pattern  out  1  sticky; set by any undecodable segment pattern; cleared by reset; reset 0
// BEHAVIOUR
//  - Decode table, input {g..a} -> code:
//      40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9,
//      08->A, 03->B, 46->C, 21->D, 06->E, 0E->F, 77->1F (underscore), 7F->10 (blank).
//      Any other pattern -> 1E and sets bad_pattern.
//  - Legal anode value: exactly one bit low (E, D, B or 7).
//  - FSM states IDLE, SETTLE, SAMPLE, WAIT_CHG. Reset state is IDLE.
//    IDLE: when an is legal -> SETTLE, settle counter := 0.
//    SETTLE: an changes -> restart SETTLE (if legal) or go to IDLE (if illegal).
//      After SETTLE_CYCLES cycles with an unchanged -> SAMPLE.
//    SAMPLE: lasts one cycle. Writes the decoded seg and dp into capture slot i, where an[i]=0,
//      and sets mask[i] -> WAIT_CHG.
//    WAIT_CHG: an changes to a legal value -> SETTLE; to an illegal value -> IDLE.
//  - Illegal anode in any state: scan_error pulse, mask cleared, stable count cleared -> IDLE.
//    Published outputs are kept.
//  - Stall: the stall counter resets on every change of an and saturates at its maximum.
//    On reaching the maximum: scan_error pulse, frame_valid := 0, mask cleared.
//  - Frame complete when mask==4'hF, checked the cycle after SAMPLE. Then mask is cleared.
//    Capture slots equal the previous complete frame -> stable_cnt+1, saturating;
//    otherwise stable_cnt := 1. Previous frame := capture slots.
//  - When stable_cnt reaches STABLE_FRAMES: copy capture slots to digit0..3,
//    frame_valid := 1, new_frame pulses once. No further pulse until the frame contents change.
//  - The same digit sampled twice before the frame completes: the later sample overwrites.
//  - Latency: outputs update 1 cycle after the frame-complete check. Reset mid-scan restarts in IDLE.
// CONFIGURATION
//  SEVSEG_DP_CAPTURE_EN
//    Defined: dp is captured per slot, included in the frame-equality compare, and drives dp_out.
//    Undefined: dp is ignored and dp_out is tied to 4'hF.
// STRUCTURE
//  Package sevseg_pkg holds:
//    segment pattern localparams
//    code constants CODE_BLANK=5'h10, CODE_INVALID=5'h1E, CODE_UNDERSCORE=5'h1F
//    the FSM state typedef
//  Sub-module seven_seg_pattern_decode: combinational 7-bit pattern to 5-bit code plus invalid flag.
// TESTING
//  1 Scan codes 1,2,3,4, SETTLE_CYCLES=4, 50 cycles per digit, 2 frames
//      -> new_frame once, digit0..3 = 1,2,3,4, frame_valid=1.
//  2 Frame A (1,2,3,4) then frame B (1,2,3,5)
//      -> no update after the first B frame; outputs become B after the second B frame.
//  3 an=4'b1100 mid-scan -> scan_error pulse, FSM goes to IDLE, previous digits kept.
//  4 seg=7'h55 on digit2 -> bad_pattern=1 (sticky), digit2 = 5'h1E once the frame is stable.
//  5 Hold an=4'b1110 for 2**TIMEOUT_W cycles -> scan_error pulse, frame_valid=0.
//  6 Assert rst_n=0 during SETTLE -> all outputs return to their reset values immediately;
//      a fresh 2-frame scan publishes correctly afterwards.
//  7 With SEVSEG_DP_CAPTURE_EN defined, dp low on digit3 only -> dp_out=4'b0111.

Source files
------------

// File: rtl/sevseg_pkg.sv
// ---------------------------------------------------------------------------
// sevseg_pkg
// Shared definitions for the seven-segment scan decoder:
//   - active-low segment patterns {g,f,e,d,c,b,a} for every decodable glyph
//   - special digit codes (blank, invalid, underscore)
//   - scan FSM state type
//   - anode helpers (legality check, one-hot-low to slot index)
// No ports (package).
// ---------------------------------------------------------------------------
package sevseg_pkg;

    localparam logic [6:0] SEG_0          = 7'h40;
    localparam logic [6:0] SEG_1          = 7'h79;
    localparam logic [6:0] SEG_2          = 7'h24;
    localparam logic [6:0] SEG_3          = 7'h30;
    localparam logic [6:0] SEG_4          = 7'h19;
    localparam logic [6:0] SEG_5          = 7'h12;
    localparam logic [6:0] SEG_6          = 7'h02;
    localparam logic [6:0] SEG_7          = 7'h78;
    localparam logic [6:0] SEG_8          = 7'h00;
    localparam logic [6:0] SEG_9          = 7'h10;
    localparam logic [6:0] SEG_A          = 7'h08;
    localparam logic [6:0] SEG_B          = 7'h03;
    localparam logic [6:0] SEG_C          = 7'h46;
    localparam logic [6:0] SEG_D          = 7'h21;
    localparam logic [6:0] SEG_E          = 7'h06;
    localparam logic [6:0] SEG_F          = 7'h0E;
    localparam logic [6:0] SEG_UNDERSCORE = 7'h77;
    localparam logic [6:0] SEG_BLANK      = 7'h7F;

    localparam logic [4:0] CODE_BLANK      = 5'h10;
    localparam logic [4:0] CODE_INVALID    = 5'h1E;
    localparam logic [4:0] CODE_UNDERSCORE = 5'h1F;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETTLE   = 2'd1,
        ST_SAMPLE   = 2'd2,
        ST_WAIT_CHG = 2'd3
    } scan_state_e;

    // Exactly one anode driven low.
    function automatic logic an_is_legal(input logic [3:0] an_v);
        logic legal;
        case (an_v)
            4'hE, 4'hD, 4'hB, 4'h7: legal = 1'b1;
            default:                legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Slot index of the low anode; only meaningful for legal patterns.
    function automatic logic [1:0] an_to_idx(input logic [3:0] an_v);
        logic [1:0] idx;
        case (an_v)
            4'hE:    idx = 2'd0;
            4'hD:    idx = 2'd1;
            4'hB:    idx = 2'd2;
            4'h7:    idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/seven_seg_pattern_decode.sv
// ---------------------------------------------------------------------------
// seven_seg_pattern_decode
// Combinational decode of an active-low segment pattern into a 5-bit code.
// Ports:
//   seg_i      in  7  {g,f,e,d,c,b,a}, active-low
//   code_o     out 5  decoded code (0-F, 10 blank, 1F underscore, 1E invalid)
//   invalid_o  out 1  high when seg_i is not in the decode table
// ---------------------------------------------------------------------------
module seven_seg_pattern_decode (
    input  logic [6:0] seg_i,
    output logic [4:0] code_o,
    output logic       invalid_o
);
    import sevseg_pkg::*;

    // Pattern lookup; anything outside the table is flagged invalid.
    always_comb begin
        code_o    = CODE_INVALID;
        invalid_o = 1'b0;
        case (seg_i)
            SEG_0:          code_o = 5'h00;
            SEG_1:          code_o = 5'h01;
            SEG_2:          code_o = 5'h02;
            SEG_3:          code_o = 5'h03;
            SEG_4:          code_o = 5'h04;
            SEG_5:          code_o = 5'h05;
            SEG_6:          code_o = 5'h06;
            SEG_7:          code_o = 5'h07;
            SEG_8:          code_o = 5'h08;
            SEG_9:          code_o = 5'h09;
            SEG_A:          code_o = 5'h0A;
            SEG_B:          code_o = 5'h0B;
            SEG_C:          code_o = 5'h0C;
            SEG_D:          code_o = 5'h0D;
            SEG_E:          code_o = 5'h0E;
            SEG_F:          code_o = 5'h0F;
            SEG_UNDERSCORE: code_o = CODE_UNDERSCORE;
            SEG_BLANK:      code_o = CODE_BLANK;
            default: begin
                code_o    = CODE_INVALID;
                invalid_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_decoder
// Receive side of a multiplexed 4-digit seven-segment bus. Follows the
// active-low anode strobes, samples each digit once its anode has settled,
// assembles complete frames and publishes a frame only after it has been
// seen identically STABLE_FRAMES times in a row.
// Optional build macro: SEVSEG_DP_CAPTURE_EN (capture decimal points into
// dp_out and include them in the frame compare; otherwise dp_out = 4'hF).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   seg[6:0], dp      active-low segments {g..a} and decimal point
//   an[3:0]           active-low anode strobes, an[0] = digit0
//   digit0..digit3    published digit codes (reset 5'h10)
//   dp_out[3:0]       published decimal points, active-low (reset 4'hF)
//   frame_valid       published frame held
//   new_frame         one-cycle pulse on publish
//   scan_error        one-cycle pulse on illegal anode or stall
//   bad_pattern       sticky: an undecodable pattern was sampled
// ---------------------------------------------------------------------------
module seven_seg_scan_decoder #(
    parameter int SETTLE_CYCLES = 4,
    parameter int STABLE_FRAMES = 2,
    parameter int TIMEOUT_W     = 18
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg,
    input  logic       dp,
    input  logic [3:0] an,
    output logic [4:0] digit0,
    output logic [4:0] digit1,
    output logic [4:0] digit2,
    output logic [4:0] digit3,
    output logic [3:0] dp_out,
    output logic       frame_valid,
    output logic       new_frame,
    output logic       scan_error,
    output logic       bad_pattern
);
    import sevseg_pkg::*;

    localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int STW = $clog2(STABLE_FRAMES + 1);
    localparam logic [TIMEOUT_W-1:0] STALL_MAX = {TIMEOUT_W{1'b1}};
    localparam logic [TIMEOUT_W-1:0] STALL_PRE = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    scan_state_e          state_q;
    logic [3:0]           an_prev_q;
    logic [SCW-1:0]       settle_cnt_q;
    logic [TIMEOUT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [3:0]           mask_q;
    logic [3:0][4:0]      slot_q, prev_q, digit_q;
    logic [STW-1:0]       stable_cnt_q, stable_cnt_d;
    logic                 sampled_q;
    logic                 frame_valid_q, new_frame_q, scan_error_q, bad_pattern_q;

    logic       an_legal_s, an_chg_s, an_err_s, stall_hit_s;
    logic       check_s, frame_eq_s, publish_s, invalid_s;
    logic [4:0] code_s;
    logic [1:0] idx_s;

`ifdef SEVSEG_DP_CAPTURE_EN
    logic [3:0] dp_slot_q, prev_dp_q, dp_out_q;
`else
    logic unused_dp_s;
    assign unused_dp_s = dp;
`endif

    seven_seg_pattern_decode u_decode (
        .seg_i     (seg),
        .code_o    (code_s),
        .invalid_o (invalid_s)
    );

    assign an_legal_s  = an_is_legal(an);
    assign an_chg_s    = (an != an_prev_q);
    // Pulse only on the transition into an illegal value, not every cycle.
    assign an_err_s    = !an_legal_s && an_chg_s;
    assign stall_hit_s = !an_chg_s && (stall_cnt_q == STALL_PRE);
    assign idx_s       = an_to_idx(an);

    assign stall_cnt_d = an_chg_s ? {TIMEOUT_W{1'b0}} :
                         (stall_cnt_q == STALL_MAX) ? STALL_MAX : stall_cnt_q + 1'b1;

`ifdef SEVSEG_DP_CAPTURE_EN
    assign frame_eq_s = (slot_q == prev_q) && (dp_slot_q == prev_dp_q);
`else
    assign frame_eq_s = (slot_q == prev_q);
`endif

    // The frame check happens the cycle after a sample landed.
    assign check_s = sampled_q && (mask_q == 4'hF) && an_legal_s && !stall_hit_s;

    assign stable_cnt_d = !frame_eq_s ? STW'(1) :
                          (stable_cnt_q == STW'(STABLE_FRAMES)) ? stable_cnt_q :
                          stable_cnt_q + STW'(1);

    // Publish on the check where the count first reaches the threshold.
    assign publish_s = check_s && (stable_cnt_d == STW'(STABLE_FRAMES)) &&
                       ((stable_cnt_q != STW'(STABLE_FRAMES)) || !frame_eq_s);

    // Scan FSM, capture slots, frame qualification and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            an_prev_q     <= 4'hF;
            settle_cnt_q  <= '0;
            stall_cnt_q   <= '0;
            mask_q        <= 4'h0;
            slot_q        <= {4{CODE_BLANK}};
            prev_q        <= {4{CODE_BLANK}};
            digit_q       <= {4{CODE_BLANK}};
            stable_cnt_q  <= '0;
            sampled_q     <= 1'b0;
            frame_valid_q <= 1'b0;
            new_frame_q   <= 1'b0;
            scan_error_q  <= 1'b0;
            bad_pattern_q <= 1'b0;
`ifdef SEVSEG_DP_CAPTURE_EN
            dp_slot_q     <= 4'hF;
            prev_dp_q     <= 4'hF;
            dp_out_q      <= 4'hF;
`endif
        end else begin
            an_prev_q    <= an;
            stall_cnt_q  <= stall_cnt_d;
            sampled_q    <= 1'b0;
            new_frame_q  <= 1'b0;
            scan_error_q <= an_err_s || stall_hit_s;

            if (!an_legal_s) begin
                state_q      <= ST_IDLE;
                mask_q       <= 4'h0;
                stable_cnt_q <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q      <= ST_SETTLE;
                        settle_cnt_q <= '0;
                    end
                    ST_SETTLE: begin
                        if (an_chg_s) begin
                            settle_cnt_q <= '0;
                        end else if (settle_cnt_q == SCW'(SETTLE_CYCLES - 1)) begin
                            state_q <= ST_SAMPLE;
                        end else begin
                            settle_cnt_q <= settle_cnt_q + SCW'(1);
                        end
                    end
                    ST_SAMPLE: begin
                        if (an_chg_s) begin
                            state_q      <= ST_SETTLE;
                            settle_cnt_q <= '0;
                        end else begin
                            slot_q[idx_s] <= code_s;
`ifdef SEVSEG_DP_CAPTURE_EN
                            dp_slot_q[idx_s] <= dp;
`endif
                            mask_q[idx_s] <= 1'b1;
                            sampled_q     <= 1'b1;
                            bad_pattern_q <= bad_pattern_q | invalid_s;
                            state_q       <= ST_WAIT_CHG;
                        end
                    end
                    ST_WAIT_CHG: begin
                        if (an_chg_s) begin
                            state_q      <= ST_SETTLE;
                            settle_cnt_q <= '0;
                        end else begin
                            state_q <= ST_WAIT_CHG;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase

                if (check_s) begin
                    mask_q       <= 4'h0;
                    stable_cnt_q <= stable_cnt_d;
                    prev_q       <= slot_q;
`ifdef SEVSEG_DP_CAPTURE_EN
                    prev_dp_q    <= dp_slot_q;
`endif
                end
            end

            if (stall_hit_s) begin
                mask_q        <= 4'h0;
                stable_cnt_q  <= '0;
                frame_valid_q <= 1'b0;
            end else if (publish_s) begin
                digit_q       <= slot_q;
                frame_valid_q <= 1'b1;
                new_frame_q   <= 1'b1;
`ifdef SEVSEG_DP_CAPTURE_EN
                dp_out_q      <= dp_slot_q;
`endif
            end
        end
    end

    assign digit0      = digit_q[0];
    assign digit1      = digit_q[1];
    assign digit2      = digit_q[2];
    assign digit3      = digit_q[3];
    assign frame_valid = frame_valid_q;
    assign new_frame   = new_frame_q;
    assign scan_error  = scan_error_q;
    assign bad_pattern = bad_pattern_q;
`ifdef SEVSEG_DP_CAPTURE_EN
    assign dp_out = dp_out_q;
`else
    assign dp_out = 4'hF;
`endif

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_scan_decoder
// Scoreboard bench: each scan that should publish pushes its expected frame;
// a monitor compares whenever new_frame pulses. Stall width is reduced so the
// stall case stays short.
// ---------------------------------------------------------------------------
module tb_seven_seg_scan_decoder;

    localparam int TW  = 8;
    localparam int DIG = 50;
`ifdef SEVSEG_DP_CAPTURE_EN
    localparam logic [3:0] DP3_EXP = 4'b0111;
`else
    localparam logic [3:0] DP3_EXP = 4'hF;
`endif

    typedef struct packed {
        logic [3:0][4:0] dig;
        logic [3:0]      dpn;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic [4:0] digit0, digit1, digit2, digit3;
    logic [3:0] dp_out;
    logic       frame_valid, new_frame, scan_error, bad_pattern;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   err_cnt = 0;

    seven_seg_scan_decoder #(
        .SETTLE_CYCLES (4),
        .STABLE_FRAMES (2),
        .TIMEOUT_W     (TW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .digit0      (digit0),
        .digit1      (digit1),
        .digit2      (digit2),
        .digit3      (digit3),
        .dp_out      (dp_out),
        .frame_valid (frame_valid),
        .new_frame   (new_frame),
        .scan_error  (scan_error),
        .bad_pattern (bad_pattern)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && new_frame === 1'b1) begin
            check("new_frame_expected", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("digit0", {27'd0, digit0}, {27'd0, e.dig[0]});
                check("digit1", {27'd0, digit1}, {27'd0, e.dig[1]});
                check("digit2", {27'd0, digit2}, {27'd0, e.dig[2]});
                check("digit3", {27'd0, digit3}, {27'd0, e.dig[3]});
                check("dp_out", {28'd0, dp_out}, {28'd0, e.dpn});
                check("frame_valid_on_pub", {31'd0, frame_valid}, 32'd1);
            end
        end
        if (rst_n === 1'b1 && scan_error === 1'b1) err_cnt++;
    end

    task automatic scan_digit(input int i, input logic [6:0] s, input logic d);
        @(posedge clk); #1;
        an  = ~(4'b0001 << i);
        seg = s;
        dp  = d;
        repeat (DIG - 1) @(posedge clk);
    endtask

    task automatic scan_frame(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3,
                              input logic [3:0] dpn);
        scan_digit(0, s0, dpn[0]);
        scan_digit(1, s1, dpn[1]);
        scan_digit(2, s2, dpn[2]);
        scan_digit(3, s3, dpn[3]);
    endtask

    task automatic push(input logic [4:0] c0, input logic [4:0] c1,
                        input logic [4:0] c2, input logic [4:0] c3,
                        input logic [3:0] dpn);
        exp_t e;
        e.dig = {c3, c2, c1, c0};
        e.dpn = dpn;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_digit0"}, {27'd0, digit0}, 32'h10);
        check({tag, "_digit1"}, {27'd0, digit1}, 32'h10);
        check({tag, "_digit2"}, {27'd0, digit2}, 32'h10);
        check({tag, "_digit3"}, {27'd0, digit3}, 32'h10);
        check({tag, "_dp_out"}, {28'd0, dp_out}, 32'hF);
        check({tag, "_frame_valid"}, {31'd0, frame_valid}, 32'd0);
        check({tag, "_new_frame"}, {31'd0, new_frame}, 32'd0);
        check({tag, "_scan_error"}, {31'd0, scan_error}, 32'd0);
        check({tag, "_bad_pattern"}, {31'd0, bad_pattern}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        an    = 4'hF;
        seg   = 7'h7F;
        dp    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("post_rst");

        // 1: frame 1,2,3,4 twice publishes once; a third copy does not re-pulse.
        scan_frame(7'h79, 7'h24, 7'h30, 7'h19, 4'hF);
        push(5'h01, 5'h02, 5'h03, 5'h04, 4'hF);
        scan_frame(7'h79, 7'h24, 7'h30, 7'h19, 4'hF);
        scan_frame(7'h79, 7'h24, 7'h30, 7'h19, 4'hF);
        check("t1_pending", exp_q.size(), 32'd0);

        // 2: frame B (1,2,3,5) needs two copies before it replaces A.
        scan_frame(7'h79, 7'h24, 7'h30, 7'h12, 4'hF);
        check("t2_digit3_held_A", {27'd0, digit3}, 32'h04);
        push(5'h01, 5'h02, 5'h03, 5'h05, 4'hF);
        scan_frame(7'h79, 7'h24, 7'h30, 7'h12, 4'hF);
        check("t2_pending", exp_q.size(), 32'd0);
        check("t2_no_errors", err_cnt, 32'd0);

        // 3: illegal anode mid-scan.
        scan_digit(0, 7'h79, 1'b1);
        scan_digit(1, 7'h24, 1'b1);
        @(posedge clk); #1;
        an = 4'b1100;
        repeat (10) @(posedge clk);
        #1;
        check("t3_err_pulses", err_cnt, 32'd1);
        check("t3_frame_valid_kept", {31'd0, frame_valid}, 32'd1);
        check("t3_digit3_kept", {27'd0, digit3}, 32'h05);
        check("t3_bad_pattern_clear", {31'd0, bad_pattern}, 32'd0);

        // 4: undecodable pattern on digit2.
        scan_frame(7'h79, 7'h24, 7'h55, 7'h19, 4'hF);
        check("t4_bad_pattern_set", {31'd0, bad_pattern}, 32'd1);
        push(5'h01, 5'h02, 5'h1E, 5'h04, 4'hF);
        scan_frame(7'h79, 7'h24, 7'h55, 7'h19, 4'hF);
        check("t4_pending", exp_q.size(), 32'd0);

        // 5: stall with the anode held.
        @(posedge clk); #1;
        an  = 4'b1110;
        seg = 7'h79;
        repeat ((1 << TW) + 40) @(posedge clk);
        #1;
        check("t5_err_pulses", err_cnt, 32'd2);
        check("t5_frame_valid_cleared", {31'd0, frame_valid}, 32'd0);
        check("t5_bad_pattern_sticky", {31'd0, bad_pattern}, 32'd1);

        // 6: reset while settling, then a fresh scan.
        scan_frame(7'h79, 7'h24, 7'h30, 7'h19, 4'hF);
        @(posedge clk); #1;
        an  = 4'b1110;
        seg = 7'h40;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        scan_frame(7'h40, 7'h77, 7'h7F, 7'h0E, 4'hF);
        push(5'h00, 5'h1F, 5'h10, 5'h0F, 4'hF);
        scan_frame(7'h40, 7'h77, 7'h7F, 7'h0E, 4'hF);
        check("t6_pending", exp_q.size(), 32'd0);

        // 7: decimal point low on digit3 only.
        scan_frame(7'h46, 7'h21, 7'h06, 7'h00, 4'b0111);
        push(5'h0C, 5'h0D, 5'h0E, 5'h08, DP3_EXP);
        scan_frame(7'h46, 7'h21, 7'h06, 7'h00, 4'b0111);
        repeat (2) @(posedge clk);
        #1;
        check("t7_pending", exp_q.size(), 32'd0);
        check("final_err_pulses", err_cnt, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
